// File: rtl/perf_pkg.sv
// Shared types and event indices for the pipeline performance monitor.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_state_e;

    localparam int EVT_STALL   = 0;
    localparam int EVT_FLUSH   = 1;
    localparam int EVT_LDUSE   = 2;
    localparam int EVT_BRTAKEN = 3;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with synchronous clear, sticky overflow flag and
// selectable saturate-or-wrap behaviour at all-ones.
module perf_counter #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Per-event performance monitor: bounded active-cycle run, parallel event
// counters, snapshot shadows and a combinational readout mux.
module pipe_perf_monitor
    import perf_pkg::*;
#(
    parameter int NUM_EVT    = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           clr_i,
    input  logic [NUM_EVT-1:0]             evt_i,
    input  logic                           snap_i,
    input  logic [$clog2(NUM_EVT+2)-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]               rd_data_o,
    output logic [CNT_W-1:0]               cycle_o,
    output logic [NUM_EVT-1:0]             ovf_o,
    output logic                           running_o,
    output logic                           done_o
);

    localparam int               SEL_W    = $clog2(NUM_EVT + 2);
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

    perf_state_e      state_q, state_d;
    logic             count_en;
    logic             cyc_ovf_unused;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] evt_cnt   [NUM_EVT];
    logic [CNT_W-1:0] evt_sh_q  [NUM_EVT];
    logic [CNT_W-1:0] evt_sh_d  [NUM_EVT];
    logic [CNT_W-1:0] cyc_sh_q, cyc_sh_d;

    // The budget check looks at the pre-edge count so DONE lands on the
    // same edge that brings the cycle count to MAX_CYCLES.
    always_comb begin
        state_d  = state_q;
        count_en = 1'b0;
        if (clr_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i) state_d = RUN;
                RUN: begin
                    if (start_i) begin
                        count_en = 1'b1;
                        if ((MAX_CYCLES != 0) && (cyc_cnt == LAST_CYC)) state_d = DONE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    perf_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cyc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .inc_i (count_en),
        .cnt_o (cyc_cnt),
        .ovf_o (cyc_ovf_unused)
    );

    for (genvar g = 0; g < NUM_EVT; g++) begin : g_evt
        perf_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_evt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clr_i),
            .inc_i (count_en & evt_i[g]),
            .cnt_o (evt_cnt[g]),
            .ovf_o (ovf_o[g])
        );
    end

    // Shadows capture the live values present before this edge's update.
    always_comb begin
        cyc_sh_d = cyc_sh_q;
        for (int k = 0; k < NUM_EVT; k++) evt_sh_d[k] = evt_sh_q[k];
        if (clr_i) begin
            cyc_sh_d = '0;
            for (int k = 0; k < NUM_EVT; k++) evt_sh_d[k] = '0;
        end else if (snap_i) begin
            cyc_sh_d = cyc_cnt;
            for (int k = 0; k < NUM_EVT; k++) evt_sh_d[k] = evt_cnt[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_sh_q <= '0;
            for (int k = 0; k < NUM_EVT; k++) evt_sh_q[k] <= '0;
        end else begin
            cyc_sh_q <= cyc_sh_d;
            for (int k = 0; k < NUM_EVT; k++) evt_sh_q[k] <= evt_sh_d[k];
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (rd_sel_i == SEL_W'(k)) rd_data_o = evt_sh_q[k];
        end
        if (rd_sel_i == SEL_W'(NUM_EVT)) rd_data_o = cyc_sh_q;
    end

    assign cycle_o   = cyc_cnt;
    assign running_o = (state_q == RUN);
    assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: directed scenarios plus randomized traffic
// against a count-level reference model.
module tb_pipe_perf_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, snap, clr;
    logic [1:0] evt, rd_sel;
    logic [7:0] rd_data, cyc;
    logic [1:0] ovf;
    logic       running, done;

    logic       s_start, s_snap, s_clr;
    logic [1:0] s_evt, s_sel;
    logic [3:0] sa_rd, sa_cyc, wr_rd, wr_cyc;
    logic [1:0] sa_ovf, wr_ovf;
    logic       sa_run, sa_done, wr_run, wr_done;

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt [2];
    int m_sh  [3];
    int m_cyc;
    bit m_ovf [2];
    bit m_run, m_done;

    pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(8), .MAX_CYCLES(64), .SATURATE(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .evt_i(evt),
        .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_data), .cycle_o(cyc),
        .ovf_o(ovf), .running_o(running), .done_o(done)
    );

    pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(1'b1)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clr_i(s_clr), .evt_i(s_evt),
        .snap_i(s_snap), .rd_sel_i(s_sel), .rd_data_o(sa_rd), .cycle_o(sa_cyc),
        .ovf_o(sa_ovf), .running_o(sa_run), .done_o(sa_done)
    );

    pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(1'b0)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clr_i(s_clr), .evt_i(s_evt),
        .snap_i(s_snap), .rd_sel_i(s_sel), .rd_data_o(wr_rd), .cycle_o(wr_cyc),
        .ovf_o(wr_ovf), .running_o(wr_run), .done_o(wr_done)
    );

    task automatic model_reset();
        m_cnt = '{0, 0};
        m_sh  = '{0, 0, 0};
        m_cyc = 0;
        m_ovf = '{0, 0};
        m_run = 0;
        m_done = 0;
    endtask

    // Count-level behaviour of one edge for the 8-bit, 64-cycle, saturating monitor.
    task automatic model_edge(input bit st, input bit [1:0] ev, input bit sn, input bit cl);
        if (cl) begin
            model_reset();
            return;
        end
        if (sn) begin
            m_sh[0] = m_cnt[0];
            m_sh[1] = m_cnt[1];
            m_sh[2] = m_cyc;
        end
        if (!m_run && !m_done) begin
            if (st) m_run = 1;
        end else if (m_run && st) begin
            if (m_cyc < 255) m_cyc = m_cyc + 1;
            for (int k = 0; k < 2; k++) begin
                if (ev[k]) begin
                    if (m_cnt[k] == 255) m_ovf[k] = 1;
                    else m_cnt[k] = m_cnt[k] + 1;
                end
            end
            if (m_cyc == 64) begin
                m_run = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic tick(input bit st, input bit [1:0] ev, input bit sn, input bit cl);
        start = st; evt = ev; snap = sn; clr = cl;
        @(posedge clk);
        model_edge(st, ev, sn, cl);
        #1;
        start = 0; snap = 0; clr = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; snap = 0; clr = 0; evt = 0; rd_sel = 0;
        s_start = 0; s_snap = 0; s_clr = 0; s_evt = 0; s_sel = 0;
        #2;
        n_tests++; if (cyc !== 8'd0) begin n_fail++; $display("FAIL reset_cycle: got %0d want 0", cyc); end
        n_tests++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL reset_ovf: got %b want 00", ovf); end
        n_tests++; if (running !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_state: run=%b done=%b want 0 0", running, done); end
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s); #1;
            n_tests++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_rd%0d: got %0d want 0", s, rd_data); end
        end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_overflow();
        int exp_sat, exp_wrap;
        s_start = 1; s_evt = 2'b01; s_snap = 1; s_sel = 0;
        @(posedge clk); #1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            exp_sat  = (e - 1 > 15) ? 15 : e - 1;
            exp_wrap = (e - 1) % 16;
            n_tests++; if (sa_rd !== 4'(exp_sat)) begin n_fail++; $display("FAIL sat_cnt_e%0d: got %0d want %0d", e, sa_rd, exp_sat); end
            n_tests++; if (wr_rd !== 4'(exp_wrap)) begin n_fail++; $display("FAIL wrap_cnt_e%0d: got %0d want %0d", e, wr_rd, exp_wrap); end
            n_tests++; if (sa_ovf[0] !== (e >= 16) || wr_ovf[0] !== (e >= 16)) begin
                n_fail++; $display("FAIL ovf_e%0d: sat=%b wrap=%b want %0d", e, sa_ovf[0], wr_ovf[0], e >= 16);
            end
            n_tests++; if (sa_cyc !== 4'((e > 15) ? 15 : e) || wr_cyc !== 4'(e % 16)) begin
                n_fail++; $display("FAIL small_cyc_e%0d: sat=%0d wrap=%0d", e, sa_cyc, wr_cyc);
            end
        end
        n_tests++; if (sa_done !== 1'b0 || wr_done !== 1'b0 || sa_run !== 1'b1) begin
            n_fail++; $display("FAIL unlimited_done: sat_done=%b wrap_done=%b sat_run=%b want 0 0 1", sa_done, wr_done, sa_run);
        end
        s_start = 0; s_snap = 0;
    endtask

    task automatic test_basic();
        logic [1:0] ev;
        tick(1, 2'b00, 0, 0);
        n_tests++; if (running !== 1'b1 || cyc !== 8'd0) begin n_fail++; $display("FAIL start_edge: run=%b cyc=%0d want 1 0", running, cyc); end
        for (int i = 0; i < 64; i++) begin
            ev = {(i % 2 == 0), 1'b1};
            tick(1, ev, 0, 0);
            if (i == 62) begin
                n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL early_done: got %b want 0", done); end
            end
        end
        n_tests++; if (done !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL done_65: done=%b run=%b want 1 0", done, running); end
        n_tests++; if (cyc !== 8'd64) begin n_fail++; $display("FAIL cycle_64: got %0d want 64", cyc); end
        tick(0, 2'b00, 1, 0);
        rd_sel = 0; #1;
        n_tests++; if (rd_data !== 8'd64) begin n_fail++; $display("FAIL basic_evt0: got %0d want 64", rd_data); end
        rd_sel = 1; #1;
        n_tests++; if (rd_data !== 8'd32) begin n_fail++; $display("FAIL basic_evt1: got %0d want 32", rd_data); end
        rd_sel = 2; #1;
        n_tests++; if (rd_data !== 8'd64) begin n_fail++; $display("FAIL basic_cycsh: got %0d want 64", rd_data); end
        rd_sel = 3; #1;
        n_tests++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL basic_sel3: got %0d want 0", rd_data); end
        for (int i = 0; i < 10; i++) tick(1, 2'b11, 0, 0);
        tick(0, 2'b00, 1, 0);
        rd_sel = 0; #1;
        n_tests++; if (rd_data !== 8'd64) begin n_fail++; $display("FAIL frozen_evt0: got %0d want 64", rd_data); end
        rd_sel = 1; #1;
        n_tests++; if (rd_data !== 8'd32) begin n_fail++; $display("FAIL frozen_evt1: got %0d want 32", rd_data); end
        n_tests++; if (cyc !== 8'd64 || done !== 1'b1) begin n_fail++; $display("FAIL frozen_cyc: cyc=%0d done=%b want 64 1", cyc, done); end
    endtask

    task automatic test_pause();
        logic [1:0] ev;
        int c = 0;
        tick(0, 2'b00, 0, 1);
        n_tests++; if (done !== 1'b0 || cyc !== 8'd0) begin n_fail++; $display("FAIL pause_clr: done=%b cyc=%0d want 0 0", done, cyc); end
        tick(1, 2'b00, 0, 0);
        for (int i = 0; i < 20; i++) begin
            ev = {(c % 2 == 0), 1'b1}; c++;
            tick(1, ev, 0, 0);
        end
        n_tests++; if (cyc !== 8'd20) begin n_fail++; $display("FAIL pause_pre: got %0d want 20", cyc); end
        for (int i = 0; i < 10; i++) begin
            tick(0, 2'b11, 0, 0);
            n_tests++; if (cyc !== 8'd20 || running !== 1'b1) begin n_fail++; $display("FAIL pause_hold%0d: cyc=%0d run=%b want 20 1", i, cyc, running); end
        end
        for (int i = 0; i < 44; i++) begin
            ev = {(c % 2 == 0), 1'b1}; c++;
            tick(1, ev, 0, 0);
            if (i == 42) begin
                n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL pause_early_done: got %b want 0", done); end
            end
        end
        n_tests++; if (done !== 1'b1 || cyc !== 8'd64) begin n_fail++; $display("FAIL pause_done_75: done=%b cyc=%0d want 1 64", done, cyc); end
        tick(0, 2'b00, 1, 0);
        rd_sel = 0; #1;
        n_tests++; if (rd_data !== 8'd64) begin n_fail++; $display("FAIL pause_evt0: got %0d want 64", rd_data); end
        rd_sel = 1; #1;
        n_tests++; if (rd_data !== 8'd32) begin n_fail++; $display("FAIL pause_evt1: got %0d want 32", rd_data); end
    endtask

    task automatic test_snap();
        tick(0, 2'b00, 0, 1);
        tick(1, 2'b00, 0, 0);
        for (int i = 0; i < 20; i++) tick(1, 2'b01, 0, 0);
        tick(1, 2'b01, 1, 0);
        n_tests++; if (cyc !== 8'd21) begin n_fail++; $display("FAIL snap_live_cyc: got %0d want 21", cyc); end
        rd_sel = 0; #1;
        n_tests++; if (rd_data !== 8'd20) begin n_fail++; $display("FAIL snap_evt0: got %0d want 20", rd_data); end
        rd_sel = 2; #1;
        n_tests++; if (rd_data !== 8'd20) begin n_fail++; $display("FAIL snap_cyc: got %0d want 20", rd_data); end
        rd_sel = 3; #1;
        n_tests++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL snap_sel3: got %0d want 0", rd_data); end
        tick(1, 2'b01, 1, 0);
        rd_sel = 0; #1;
        n_tests++; if (rd_data !== 8'd21) begin n_fail++; $display("FAIL snap_next: got %0d want 21", rd_data); end
    endtask

    task automatic test_rst_mid();
        tick(0, 2'b00, 0, 1);
        tick(1, 2'b00, 0, 0);
        for (int i = 0; i < 30; i++) tick(1, 2'b11, (i == 24), 0);
        rd_sel = 2; #1;
        n_tests++; if (cyc !== 8'd30 || rd_data !== 8'd24) begin n_fail++; $display("FAIL rst_pre: cyc=%0d rd=%0d want 30 24", cyc, rd_data); end
        rst = 1; #2;
        n_tests++; if (cyc !== 8'd0 || ovf !== 2'b00) begin n_fail++; $display("FAIL rst_async_cnt: cyc=%0d ovf=%b want 0 00", cyc, ovf); end
        n_tests++; if (running !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_async_state: run=%b done=%b want 0 0", running, done); end
        n_tests++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL rst_async_rd: got %0d want 0", rd_data); end
        #1; rst = 0;
        model_reset();
        tick(1, 2'b01, 0, 0);
        n_tests++; if (running !== 1'b1 || cyc !== 8'd0) begin n_fail++; $display("FAIL rst_restart: run=%b cyc=%0d want 1 0", running, cyc); end
        tick(1, 2'b01, 0, 0);
        n_tests++; if (cyc !== 8'd1) begin n_fail++; $display("FAIL rst_first_cnt: got %0d want 1", cyc); end
    endtask

    task automatic test_clr_snap_done();
        int budget = 0;
        while (!done && budget < 200) begin
            tick(1, 2'b11, 0, 0);
            budget++;
        end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_timeout: done=%b after %0d cycles want 1", done, budget); end
        tick(0, 2'b00, 1, 0);
        rd_sel = 0; #1;
        n_tests++; if (rd_data !== 8'd64) begin n_fail++; $display("FAIL pre_clr_snap: got %0d want 64", rd_data); end
        tick(1, 2'b11, 1, 1);
        n_tests++; if (cyc !== 8'd0 || ovf !== 2'b00) begin n_fail++; $display("FAIL clr_cnt: cyc=%0d ovf=%b want 0 00", cyc, ovf); end
        n_tests++; if (running !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL clr_state: run=%b done=%b want 0 0", running, done); end
        for (int s = 0; s < 3; s++) begin
            rd_sel = 2'(s); #1;
            n_tests++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL clr_shadow%0d: got %0d want 0", s, rd_data); end
        end
    endtask

    task automatic test_random();
        bit         st, sn, cl;
        logic [1:0] ev;
        int         exp_rd;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 9) != 0);
            ev = 2'($urandom);
            sn = ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 39) == 0);
            rd_sel = 2'($urandom);
            tick(st, ev, sn, cl);
            exp_rd = (rd_sel < 3) ? m_sh[rd_sel] : 0;
            n_tests++;
            if (cyc !== 8'(m_cyc) || ovf !== {m_ovf[1], m_ovf[0]} || running !== m_run ||
                done !== m_done || rd_data !== 8'(exp_rd)) begin
                n_fail++;
                $display("FAIL random_%0d: cyc=%0d/%0d ovf=%b/%b%b run=%b/%b done=%b/%b rd[%0d]=%0d/%0d",
                         i, cyc, m_cyc, ovf, m_ovf[1], m_ovf[0], running, m_run, done, m_done,
                         rd_sel, rd_data, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_basic();
        test_pause();
        test_snap();
        test_rst_mid();
        test_clr_snap_done();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
